tristate_bus_port: RTL and testbench
====================================

Name: tristate_bus_port

Overview:
- Parametrised bidirectional bus port for the PEB-side data bus.
- Generalises the fixed 8-bit tristate buffer with:
  - configurable width
  - a registered output-data latch
  - enforced Z turnaround cycles on every direction change, so the bus is never contended
  - synchronised input capture with a valid qualifier and change detection
- Sits between the pad-level inout bus and the internal register/CRU logic.

Parameters:
- WIDTH, 8, data bus width in bits (1..32).
- TURNAROUND, 2, number of Z cycles inserted on each direction change (>=1).
- SYNC_STAGES, 2, depth of the input synchroniser flop chain (>=1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- drive_req  input  1  level request to drive the bus (1) or listen (0).
- wr_stb  input  1  load wr_data into the output latch this cycle.
- wr_data  input  WIDTH  data to present on the bus.
- bus_io  inout  WIDTH  pad-side bus; driven with the output latch only while bus_oe=1, else Z.
- bus_oe  output  1  registered output enable (1 only in DRIVE).
- driving  output  1  equals bus_oe (status for upstream logic).
- busy  output  1  1 in TURN_ON or TURN_OFF.
- rd_data  output  WIDTH  last synchroniser stage of the bus value.
- rd_valid  output  1  1 when rd_data reflects a bus value sampled entirely in LISTEN.
- rd_change  output  1  one-cycle pulse when rd_data differs from its previous value while rd_valid=1.

Behaviour:
- State machine with four states:
  - LISTEN: bus Z; input sampling active.
  - TURN_ON: bus Z; counting TURNAROUND cycles before driving.
  - DRIVE: bus driven.
  - TURN_OFF: bus Z; counting TURNAROUND cycles after driving.
- Reset (synchronous): on any edge with reset=1:
  - state=LISTEN, turnaround counter=0, output latch=0.
  - synchroniser flops=0, valid counter=0.
  - bus_oe=0, driving=0, busy=0, rd_data=0, rd_valid=0, rd_change=0.
  - Reset mid-DRIVE releases the bus (Z) after that same edge.
- Transitions (evaluated each rising edge, reset=0):
  - LISTEN, drive_req=1 -> TURN_ON; counter loads TURNAROUND-1.
  - TURN_ON, drive_req=0 -> LISTEN immediately. No turnaround is needed because the bus was never driven.
  - TURN_ON, counter=0, drive_req=1 -> DRIVE. Otherwise decrement the counter.
  - DRIVE, drive_req=0 -> TURN_OFF; counter loads TURNAROUND-1.
  - TURN_OFF, counter=0 -> LISTEN, regardless of drive_req. A re-request during TURN_OFF is honoured only after reaching LISTEN: the full sequence TURN_OFF -> LISTEN (1 cycle) -> TURN_ON runs, with no shortcut.
- Latency:
  - drive_req rising, sampled at edge n: bus_oe=1 after edge n+TURNAROUND.
  - drive_req falling, sampled at edge m: bus_oe=0 after edge m.
- bus_oe is a registered output, decoded as next_state==DRIVE, so it is glitch-free.
- Output latch:
  - Loads wr_data on wr_stb=1 in any state, including while driving.
  - The new value appears on bus_io the cycle after the strobe edge.
  - Latch contents are held across direction changes.
- Input path:
  - bus_io is shifted through the SYNC_STAGES flops every cycle; rd_data is the last stage.
  - The valid counter clears on leaving LISTEN and counts up to SYNC_STAGES while in LISTEN.
  - rd_valid=1 when in LISTEN and the counter has reached SYNC_STAGES; otherwise 0.
  - rd_data keeps shifting in all states; consumers must qualify it with rd_valid.
- rd_change:
  - Registered compare of rd_data against its prior value.
  - Pulses only when rd_valid was 1 on both cycles of the comparison.
  - It never pulses on the first valid cycle.
- Simultaneous events:
  - wr_stb on the same edge as DRIVE entry: the new data is driven from the first DRIVE cycle.
  - reset has priority over all other inputs.

Optional Feature:
- TRISTATE_CHANGE_DETECT_EN
- Defined: the rd_change compare register and pulse logic are built as described above.
- Undefined: the compare logic is omitted and rd_change is tied to 0. All other behaviour is identical.

Test Plan:
- Reset with drive_req=0 and bus_io externally Z, then hold 3 cycles -> bus_io===Z, bus_oe=0, busy=0; rd_valid=1 on the SYNC_STAGES-th cycle after reset.
- wr_stb with wr_data=8'hA5, then raise drive_req -> busy=1 for exactly 2 cycles with bus_io===Z; then bus_oe=1 and bus_io=8'hA5.
- While driving, wr_stb with 8'hFF -> bus_io=8'hFF on the next cycle; bus_oe stays 1.
- Drop drive_req -> bus_io===Z after that edge; busy=1 for 2 cycles; then LISTEN. With an external driver on bus_io of 8'h3C: rd_valid=1 after 2 further cycles and rd_data=8'h3C.
- Raise drive_req, then drop it after 1 cycle (mid TURN_ON) -> return to LISTEN; bus_oe never asserts.
- In LISTEN with rd_valid=1, external bus changes 8'h3C->8'h5A -> rd_change pulses once, for 1 cycle, when rd_data becomes 8'h5A. With the macro undefined, rd_change stays 0.
- Assert reset during DRIVE -> bus_io===Z and all outputs 0 after that edge.

Source files
------------

// File: rtl/tristate_bus_port_if.sv
// tristate_bus_port_if: control, write and capture signals of tristate_bus_port.
// The pad-side bus itself stays a plain inout net on the port module.
interface tristate_bus_port_if #(
  parameter int WIDTH = 8
);
  logic drive_req;
  logic wr_stb;
  logic [WIDTH-1:0] wr_data;
  logic bus_oe;
  logic driving;
  logic busy;
  logic [WIDTH-1:0] rd_data;
  logic rd_valid;
  logic rd_change;
  modport master (
    output drive_req, wr_stb, wr_data,
    input bus_oe, driving, busy, rd_data, rd_valid, rd_change
  );
  modport slave (
    input drive_req, wr_stb, wr_data,
    output bus_oe, driving, busy, rd_data, rd_valid, rd_change
  );
endinterface

// File: rtl/tristate_bus_port.sv
// tristate_bus_port: bidirectional bus port with Z turnaround and synchronised capture.
// Define TRISTATE_CHANGE_DETECT_EN to build the rd_change detector; otherwise rd_change is 0.
module tristate_bus_port #(
  parameter int WIDTH = 8,
  parameter int TURNAROUND = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  inout wire [WIDTH-1:0] bus_io,
  tristate_bus_port_if.slave bus
);
  localparam int CW = TURNAROUND > 1 ? $clog2(TURNAROUND) : 1;
  localparam int VW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TURNAROUND - 1);
  localparam logic [VW-1:0] VMAX = VW'(SYNC_STAGES);
  typedef enum logic [1:0] {LISTEN, TURN_ON, DRIVE, TURN_OFF} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [VW-1:0] vcnt, vcnt_nxt;
  logic [WIDTH-1:0] latch;
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] sync_nxt [SYNC_STAGES];
  logic oe, busy, valid, valid_nxt;
  always_comb begin
    nxt = state;
    case (state)
      LISTEN: nxt = bus.drive_req ? TURN_ON : LISTEN;
      TURN_ON: nxt = !bus.drive_req ? LISTEN : (cnt == '0 ? DRIVE : TURN_ON);
      DRIVE: nxt = bus.drive_req ? DRIVE : TURN_OFF;
      TURN_OFF: nxt = cnt == '0 ? LISTEN : TURN_OFF;
      default: nxt = LISTEN;
    endcase
  end
  // Outputs decode the next state so they change together with the state register.
  always_ff @(posedge clk)
    if (reset) begin
      state <= LISTEN;
      cnt <= '0;
      oe <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? CNT_LOAD : cnt - CW'(cnt != '0);
      oe <= nxt == DRIVE;
      busy <= nxt == TURN_ON || nxt == TURN_OFF;
    end
  // A sample counts towards validity only if taken with LISTEN on both sides of the edge.
  always_comb begin
    sync_nxt[0] = bus_io;
    for (int i = 1; i < SYNC_STAGES; i++) sync_nxt[i] = sync[i-1];
    vcnt_nxt = (state == LISTEN && nxt == LISTEN) ? vcnt + VW'(vcnt != VMAX) : '0;
    valid_nxt = nxt == LISTEN && vcnt_nxt == VMAX;
  end
  always_ff @(posedge clk)
    if (reset) begin
      latch <= '0;
      vcnt <= '0;
      valid <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      if (bus.wr_stb) latch <= bus.wr_data;
      vcnt <= vcnt_nxt;
      valid <= valid_nxt;
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= sync_nxt[i];
    end
`ifdef TRISTATE_CHANGE_DETECT_EN
  logic change;
  always_ff @(posedge clk)
    if (reset) change <= 1'b0;
    else change <= valid_nxt && valid && sync_nxt[SYNC_STAGES-1] != sync[SYNC_STAGES-1];
  assign bus.rd_change = change;
`else
  assign bus.rd_change = 1'b0;
`endif
  assign bus_io = oe ? latch : 'z;
  assign bus.bus_oe = oe;
  assign bus.driving = oe;
  assign bus.busy = busy;
  assign bus.rd_data = sync[SYNC_STAGES-1];
  assign bus.rd_valid = valid;
endmodule

// File: tb/tb_tristate_bus_port.sv
// tb_tristate_bus_port: directed bench for tristate_bus_port with a cycle model and per-cycle compare.
// A released bus reads as Z, or as 0 where the simulator has no Z state.
module tb_tristate_bus_port;
  localparam int W = 8;
  localparam int T = 2;
  localparam int S = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ext_en = 1'b0;
  logic [W-1:0] ext_val = '0;
  wire [W-1:0] bus_io;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int pulses;
  tristate_bus_port_if #(.WIDTH(W)) bif();
  tristate_bus_port #(.WIDTH(W), .TURNAROUND(T), .SYNC_STAGES(S)) dut (
    .clk(clk),
    .reset(reset),
    .bus_io(bus_io),
    .bus(bif)
  );
  assign bus_io = ext_en ? ext_val : 'z;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Model: req_run counts consecutive requesting edges while idle, rel_left counts release edges left.
  int req_run = 0, rel_left = 0, listen_run = 0;
  bit m_oe = 0, m_busy = 0, m_valid = 0, m_change = 0, pk = 1;
  logic [W-1:0] m_latch = '0;
  logic [W-1:0] hv [S];
  bit hk [S];
  initial for (int i = 0; i < S; i++) begin hv[i] = '0; hk[i] = 1'b1; end
  always @(posedge clk) begin
    logic [W-1:0] smp, prev_rd;
    bit sk, was_listen, is_listen, prev_valid;
    smp = m_oe ? m_latch : (ext_en ? ext_val : '0);
    sk = m_oe || ext_en;
    was_listen = !m_oe && req_run == 0 && rel_left == 0;
    prev_rd = hv[S-1];
    prev_valid = m_valid;
    if (reset) begin
      req_run = 0; rel_left = 0; listen_run = 0;
      m_oe = 0; m_busy = 0; m_valid = 0; m_change = 0; pk = 1;
      m_latch = '0;
      for (int i = 0; i < S; i++) begin hv[i] = '0; hk[i] = 1'b1; end
    end else begin
      if (m_oe) begin
        if (!bif.drive_req) begin m_oe = 0; rel_left = T; end
      end else if (rel_left > 0) rel_left--;
      else begin
        req_run = bif.drive_req ? req_run + 1 : 0;
        if (req_run > T) begin m_oe = 1; req_run = 0; end
      end
      m_busy = rel_left > 0 || req_run > 0;
      is_listen = !m_oe && req_run == 0 && rel_left == 0;
      listen_run = (was_listen && is_listen) ? listen_run + 1 : 0;
      m_valid = is_listen && listen_run >= S;
      pk = hk[S-1];
      for (int i = S - 1; i > 0; i--) begin hv[i] = hv[i-1]; hk[i] = hk[i-1]; end
      hv[0] = smp;
      hk[0] = sk;
`ifdef TRISTATE_CHANGE_DETECT_EN
      m_change = m_valid && prev_valid && hv[S-1] != prev_rd;
`else
      m_change = 0;
`endif
      if (bif.wr_stb) m_latch = bif.wr_data;
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("bus_oe", {31'b0, bif.bus_oe}, {31'b0, m_oe});
    chk("driving", {31'b0, bif.driving}, {31'b0, m_oe});
    chk("busy", {31'b0, bif.busy}, {31'b0, m_busy});
    chk("rd_valid", {31'b0, bif.rd_valid}, {31'b0, m_valid});
    if ((hk[S-1] && pk) || !m_valid) chk("rd_change", {31'b0, bif.rd_change}, {31'b0, m_change});
    if (m_valid && hk[S-1]) chk("rd_data", {24'b0, bif.rd_data}, {24'b0, hv[S-1]});
    if (m_oe) chk("bus_drv", {24'b0, bus_io}, {24'b0, m_latch});
    else if (ext_en) chk("bus_ext", {24'b0, bus_io}, {24'b0, ext_val});
    else chk("bus_z", {31'b0, (bus_io === 8'hzz) || (bus_io === 8'h00)}, 32'd1);
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bif.drive_req = 1'b0;
    bif.wr_stb = 1'b0;
    bif.wr_data = '0;
    cyc(2);
    chk_on = 1'b1;
    chk("rst_oe", {31'b0, bif.bus_oe}, 32'd0);
    chk("rst_valid", {31'b0, bif.rd_valid}, 32'd0);
    reset = 1'b0;
    cyc(1);
    chk("valid_early", {31'b0, bif.rd_valid}, 32'd0);
    cyc(1);
    chk("valid_after_rst", {31'b0, bif.rd_valid}, 32'd1);
    cyc(1);
    bif.wr_stb = 1'b1; bif.wr_data = 8'hA5;
    cyc(1);
    bif.wr_stb = 1'b0; bif.drive_req = 1'b1;
    cyc(1);
    chk("turn_on_busy1", {31'b0, bif.busy}, 32'd1);
    cyc(1);
    chk("turn_on_busy2", {31'b0, bif.busy}, 32'd1);
    chk("turn_on_oe", {31'b0, bif.bus_oe}, 32'd0);
    cyc(1);
    chk("drive_oe", {31'b0, bif.bus_oe}, 32'd1);
    chk("drive_a5", {24'b0, bus_io}, 32'h0000_00A5);
    bif.wr_stb = 1'b1; bif.wr_data = 8'hFF;
    cyc(1);
    bif.wr_stb = 1'b0;
    chk("drive_ff", {24'b0, bus_io}, 32'h0000_00FF);
    bif.drive_req = 1'b0;
    cyc(1);
    chk("off_oe", {31'b0, bif.bus_oe}, 32'd0);
    ext_en = 1'b1; ext_val = 8'h3C;
    cyc(2);
    chk("listen_busy", {31'b0, bif.busy}, 32'd0);
    cyc(1);
    chk("listen_valid_early", {31'b0, bif.rd_valid}, 32'd0);
    cyc(1);
    chk("listen_valid", {31'b0, bif.rd_valid}, 32'd1);
    chk("listen_3c", {24'b0, bif.rd_data}, 32'h0000_003C);
    bif.drive_req = 1'b1;
    cyc(1);
    bif.drive_req = 1'b0;
    cyc(1);
    chk("abort_oe", {31'b0, bif.bus_oe}, 32'd0);
    chk("abort_busy", {31'b0, bif.busy}, 32'd0);
    cyc(3);
    ext_val = 8'h5A;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      pulses += int'(bif.rd_change);
    end
    chk("rd_5a", {24'b0, bif.rd_data}, 32'h0000_005A);
`ifdef TRISTATE_CHANGE_DETECT_EN
    chk("change_pulses", pulses, 32'd1);
`else
    chk("change_pulses", pulses, 32'd0);
`endif
    bif.drive_req = 1'b1; ext_en = 1'b0;
    cyc(2);
    bif.wr_stb = 1'b1; bif.wr_data = 8'hC3;
    cyc(1);
    bif.wr_stb = 1'b0;
    chk("entry_c3", {24'b0, bus_io}, 32'h0000_00C3);
    bif.drive_req = 1'b0;
    cyc(1);
    bif.drive_req = 1'b1;
    cyc(2);
    chk("rereq_listen", {31'b0, bif.busy}, 32'd0);
    cyc(3);
    chk("rereq_drive", {31'b0, bif.bus_oe}, 32'd1);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_oe", {31'b0, bif.bus_oe}, 32'd0);
    chk("mid_rst_busy", {31'b0, bif.busy}, 32'd0);
    reset = 1'b0; bif.drive_req = 1'b0;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
